// File: rtl/uart_rx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared receive-control state encodings and status bit indices.
// Revision: 1.0
// ============================================================================
package uart_pkg;

   localparam logic [1:0] CTRL_OFF      = 2'd0;
   localparam logic [1:0] CTRL_FLUSH    = 2'd1;
   localparam logic [1:0] CTRL_ACTIVE   = 2'd2;
   localparam logic [1:0] CTRL_STOPPING = 2'd3;

   typedef enum logic [1:0] {
      ST_OFF      = CTRL_OFF,
      ST_FLUSH    = CTRL_FLUSH,
      ST_ACTIVE   = CTRL_ACTIVE,
      ST_STOPPING = CTRL_STOPPING
   } ctrl_state_e;

   // Bit positions of the sticky flags in the APB status register
   localparam int STS_OVERRUN_BIT   = 0;
   localparam int STS_FRAME_ERR_BIT = 1;

   function automatic logic capture_allowed(input ctrl_state_e s);
      return (s == ST_ACTIVE) || (s == ST_STOPPING);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl_if
// Brief   : Config, receiver-strobe, FIFO-read and status bundle of the RX path.
// Revision: 1.0
// ============================================================================
interface uart_rx_ctrl_if #(
   parameter int DATA_BITS = 8,
   parameter int AW        = 4
);
   logic                 cfg_en;
   logic                 cfg_flush;
   logic [AW:0]          cfg_thresh;
   logic                 clr_err;
   logic                 rx_done;
   logic                 rx_busy;
   logic                 rx_error;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_en;
   logic                 rx_rst;
   logic                 rd_req;
   logic [DATA_BITS-1:0] rd_data;
   logic [AW:0]          fifo_level;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic                 sts_overrun;
   logic                 sts_frame_err;
   logic                 irq;
   logic [1:0]           ctrl_state;

   modport slave (
      input  cfg_en, cfg_flush, cfg_thresh, clr_err,
      input  rx_done, rx_busy, rx_error, rx_data, rd_req,
      output rx_en, rx_rst, rd_data, fifo_level, fifo_empty, fifo_full,
      output sts_overrun, sts_frame_err, irq, ctrl_state
   );

   modport master (
      output cfg_en, cfg_flush, cfg_thresh, clr_err,
      output rx_done, rx_busy, rx_error, rx_data, rd_req,
      input  rx_en, rx_rst, rd_data, fifo_level, fifo_empty, fifo_full,
      input  sts_overrun, sts_frame_err, irq, ctrl_state
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : Synchronous first-word-fall-through FIFO with flush.
// Revision: 1.0
// ============================================================================
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 16
) (
   input  wire logic                        PCLK,
   input  wire logic                        PRESETn,
   input  wire logic                        i_push,
   input  wire logic                        i_pop,
   input  wire logic                        i_flush,
   input  wire logic [DATA_BITS-1:0]        i_wdata,
   output logic      [DATA_BITS-1:0]        o_rd_data,
   output logic      [$clog2(DEPTH):0]      o_level,
   output logic                             o_empty,
   output logic                             o_full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_full_lvl = DEPTH[AW:0];

   logic [DATA_BITS-1:0] r_mem [DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_level;
   logic [DATA_BITS-1:0] r_rd_data;

   logic                 w_pop;
   logic                 w_push;
   logic [AW-1:0]        w_rd_ptr_nxt;
   logic [AW:0]          w_level_nxt;

   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign w_pop        = i_pop && (r_level != '0);
   assign w_push       = i_push && ((r_level != c_full_lvl) || w_pop);
   assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + 1'b1) : r_rd_ptr;

   always_comb begin
      w_level_nxt = r_level;
      if (w_push && !w_pop) begin
         w_level_nxt = r_level + 1'b1;
      end else if (!w_push && w_pop) begin
         w_level_nxt = r_level - 1'b1;
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESETn && !i_flush && w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Head is registered so an empty FIFO holds its last head instead of stale memory
   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_rd_data <= '0;
      end else if (i_flush) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         r_rd_ptr <= w_rd_ptr_nxt;
         r_level  <= w_level_nxt;
         if (w_level_nxt != '0) begin
            r_rd_data <= (w_push && (r_wr_ptr == w_rd_ptr_nxt)) ? i_wdata
                                                                : r_mem[w_rd_ptr_nxt];
         end
      end
   end

   assign o_rd_data = r_rd_data;
   assign o_level   = r_level;
   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == c_full_lvl);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : UART receive sequencer, frame capture FIFO, sticky status and irq.
// Revision: 1.0
// ============================================================================
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int FLUSH_CYCLES = 4
) (
   input  wire logic       PCLK,
   input  wire logic       PRESETn,
   uart_rx_ctrl_if.slave   bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] c_flush_last = CW'(FLUSH_CYCLES - 1);

   ctrl_state_e          r_state;
   logic                 r_rx_en;
   logic                 r_rx_rst;
   logic [CW-1:0]        r_flush_cnt;
   logic                 r_overrun;
   logic                 r_frame_err;
   logic                 r_irq;

   logic                 w_capture;
   logic                 w_push;
   logic                 w_frame_err_set;
   logic                 w_overrun_set;
   logic                 w_level_hit;
   logic [AW:0]          w_level;
   logic                 w_empty;
   logic                 w_full;
   logic [DATA_BITS-1:0] w_rd_data;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_state     <= ST_OFF;
         r_rx_en     <= 1'b0;
         r_rx_rst    <= 1'b0;
         r_flush_cnt <= '0;
      end else begin
         case (r_state)
            ST_OFF: begin
               if (bus.cfg_en) begin
                  r_state     <= ST_FLUSH;
                  r_rx_rst    <= 1'b1;
                  r_flush_cnt <= '0;
               end
            end
            ST_FLUSH: begin
               if (!bus.cfg_en) begin
                  r_state  <= ST_OFF;
                  r_rx_rst <= 1'b0;
               end else if (r_flush_cnt == c_flush_last) begin
                  r_state  <= ST_ACTIVE;
                  r_rx_rst <= 1'b0;
                  r_rx_en  <= 1'b1;
               end else begin
                  r_flush_cnt <= r_flush_cnt + 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (!bus.cfg_en) begin
                  r_rx_en <= 1'b0;
                  r_state <= bus.rx_busy ? ST_STOPPING : ST_OFF;
               end
            end
            ST_STOPPING: begin
               // Receiver is left to finish its frame with rx_en low
               if (!bus.rx_busy) begin
                  r_state <= ST_OFF;
               end else if (bus.cfg_en) begin
                  r_state <= ST_ACTIVE;
                  r_rx_en <= 1'b1;
               end
            end
            default: begin
               r_state  <= ST_OFF;
               r_rx_en  <= 1'b0;
               r_rx_rst <= 1'b0;
            end
         endcase
      end
   end

   assign w_capture       = capture_allowed(r_state) && bus.rx_done;
   assign w_frame_err_set = w_capture && bus.rx_error;
   assign w_push          = w_capture && !bus.rx_error;
   assign w_overrun_set   = w_push && w_full && !bus.rd_req;

   uart_rx_fifo #(
      .DATA_BITS (DATA_BITS),
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .i_push    (w_push),
      .i_pop     (bus.rd_req),
      .i_flush   (bus.cfg_flush),
      .i_wdata   (bus.rx_data),
      .o_rd_data (w_rd_data),
      .o_level   (w_level),
      .o_empty   (w_empty),
      .o_full    (w_full)
   );

   // Flush beats everything; a set event beats a same-cycle clear
   always_ff @(posedge PCLK) begin
      if (!PRESETn || bus.cfg_flush) begin
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_overrun_set) begin
            r_overrun <= 1'b1;
         end else if (bus.clr_err) begin
            r_overrun <= 1'b0;
         end
         if (w_frame_err_set) begin
            r_frame_err <= 1'b1;
         end else if (bus.clr_err) begin
            r_frame_err <= 1'b0;
         end
      end
   end

   assign w_level_hit = (bus.cfg_thresh != '0) && (w_level >= bus.cfg_thresh);

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= w_level_hit || r_overrun || r_frame_err;
      end
   end

   assign bus.rx_en         = r_rx_en;
   assign bus.rx_rst        = r_rx_rst;
   assign bus.rd_data       = w_rd_data;
   assign bus.fifo_level    = w_level;
   assign bus.fifo_empty    = w_empty;
   assign bus.fifo_full     = w_full;
   assign bus.sts_overrun   = r_overrun;
   assign bus.sts_frame_err = r_frame_err;
   assign bus.irq           = r_irq;
   assign bus.ctrl_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Brief   : Directed bench for uart_rx_ctrl with a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_uart_rx_ctrl;
   localparam int DB    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int FLUSH = 4;

   logic PCLK    = 1'b0;
   logic PRESETn = 1'b0;
   always #5 PCLK = ~PCLK;

   uart_rx_ctrl_if #(.DATA_BITS(DB), .AW(AW)) bus ();

   uart_rx_ctrl #(
      .DATA_BITS    (DB),
      .FIFO_DEPTH   (DEPTH),
      .FLUSH_CYCLES (FLUSH)
   ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: spec-level state number, flush countdown, queue FIFO
   int         m_state = 0;
   int         m_flush_left = 0;
   logic [7:0] m_q[$];
   logic [7:0] m_head = 8'h00;
   bit         m_ovr = 0, m_ferr = 0, m_irq = 0;

   always @(posedge PCLK) begin
      bit cap, pop, push, full, ovr_set, ferr_set;
      if (!PRESETn) begin
         m_state = 0; m_q.delete(); m_head = 8'h00;
         m_ovr = 0; m_ferr = 0; m_irq = 0;
      end else begin
         m_irq = ((bus.cfg_thresh != 0) && (m_q.size() >= int'(bus.cfg_thresh))) || m_ovr || m_ferr;
         cap      = (m_state == 2 || m_state == 3) && bus.rx_done;
         ferr_set = cap && bus.rx_error;
         full     = (m_q.size() == DEPTH);
         ovr_set  = cap && !bus.rx_error && full && !bus.rd_req;
         if (bus.cfg_flush) begin
            m_q.delete(); m_ovr = 0; m_ferr = 0;
         end else begin
            pop  = bus.rd_req && (m_q.size() > 0);
            push = cap && !bus.rx_error && (!full || pop);
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(bus.rx_data);
            m_ovr  = ovr_set  ? 1'b1 : (bus.clr_err ? 1'b0 : m_ovr);
            m_ferr = ferr_set ? 1'b1 : (bus.clr_err ? 1'b0 : m_ferr);
         end
         if (m_q.size() > 0) m_head = m_q[0];
         case (m_state)
            0: if (bus.cfg_en) begin m_state = 1; m_flush_left = FLUSH; end
            1: if (!bus.cfg_en) m_state = 0;
               else begin
                  m_flush_left--;
                  if (m_flush_left == 0) m_state = 2;
               end
            2: if (!bus.cfg_en) m_state = bus.rx_busy ? 3 : 0;
            3: if (!bus.rx_busy) m_state = 0; else if (bus.cfg_en) m_state = 2;
            default: m_state = 0;
         endcase
      end
   end

   always @(posedge PCLK) begin
      #1;
      check("m.state",     32'(bus.ctrl_state),    32'(m_state));
      check("m.rx_en",     32'(bus.rx_en),         32'(m_state == 2));
      check("m.rx_rst",    32'(bus.rx_rst),        32'(m_state == 1));
      check("m.level",     32'(bus.fifo_level),    32'(m_q.size()));
      check("m.empty",     32'(bus.fifo_empty),    32'(m_q.size() == 0));
      check("m.full",      32'(bus.fifo_full),     32'(m_q.size() == DEPTH));
      check("m.rd_data",   32'(bus.rd_data),       32'(m_head));
      check("m.overrun",   32'(bus.sts_overrun),   32'(m_ovr));
      check("m.frame_err", 32'(bus.sts_frame_err), 32'(m_ferr));
      check("m.irq",       32'(bus.irq),           32'(m_irq));
   end

   task automatic tick();
      @(negedge PCLK);
   endtask

   task automatic frame(input logic [7:0] d, input logic err);
      bus.rx_done = 1'b1; bus.rx_data = d; bus.rx_error = err;
      tick();
      bus.rx_done = 1'b0; bus.rx_error = 1'b0;
   endtask

   task automatic pop_one();
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] exp_bytes [3];

   initial begin
      int rst_cycles;
      bus.cfg_en = 0; bus.cfg_flush = 0; bus.cfg_thresh = '0; bus.clr_err = 0;
      bus.rx_done = 0; bus.rx_busy = 0; bus.rx_error = 0; bus.rx_data = '0; bus.rd_req = 0;
      repeat (3) tick();
      check("rst.state", 32'(bus.ctrl_state), 0);
      check("rst.empty", 32'(bus.fifo_empty), 1);
      check("rst.irq",   32'(bus.irq),        0);
      PRESETn = 1'b1;
      tick();

      // Enable: rx_rst for exactly FLUSH cycles, then ACTIVE
      bus.cfg_en = 1'b1;
      rst_cycles = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.rx_rst) rst_cycles++;
         if (bus.ctrl_state == 2'd2) break;
      end
      check("en.rst_cycles", 32'(rst_cycles), 4);
      check("en.rx_en",      32'(bus.rx_en), 1);
      check("en.state",      32'(bus.ctrl_state), 2);

      // Three frames then drain; level threshold 3
      bus.cfg_thresh = 5'd3;
      exp_bytes[0] = 8'h16; exp_bytes[1] = 8'h32; exp_bytes[2] = 8'hAF;
      for (int i = 0; i < 3; i++) frame(exp_bytes[i], 1'b0);
      check("three.level", 32'(bus.fifo_level), 3);
      check("three.head",  32'(bus.rd_data), 32'h16);
      check("three.irq_trail", 32'(bus.irq), 0);
      tick();
      check("three.irq", 32'(bus.irq), 1);
      for (int i = 0; i < 3; i++) begin
         check("pop.data", 32'(bus.rd_data), 32'(exp_bytes[i]));
         pop_one();
      end
      check("pop.empty", 32'(bus.fifo_empty), 1);
      pop_one();
      check("pop.empty_ignored", 32'(bus.fifo_level), 0);

      // Fill to 16, 17th frame overruns; threshold beyond depth disables level irq
      bus.cfg_thresh = 5'd20;
      for (int i = 0; i < 16; i++) frame(8'h40 + 8'(i), 1'b0);
      check("fill.full",  32'(bus.fifo_full), 1);
      frame(8'hEE, 1'b0);
      check("ovr.level", 32'(bus.fifo_level), 16);
      check("ovr.flag",  32'(bus.sts_overrun), 1);
      tick();
      check("ovr.irq",  32'(bus.irq), 1);
      check("ovr.head", 32'(bus.rd_data), 32'h40);

      // Flush, refill, then push and pop in the same cycle while full
      bus.cfg_flush = 1'b1; tick(); bus.cfg_flush = 1'b0;
      check("flush.level", 32'(bus.fifo_level), 0);
      check("flush.ovr",   32'(bus.sts_overrun), 0);
      for (int i = 0; i < 16; i++) frame(8'h40 + 8'(i), 1'b0);
      tick();
      check("thresh20.irq", 32'(bus.irq), 0);
      bus.rd_req = 1'b1;
      frame(8'h99, 1'b0);
      bus.rd_req = 1'b0;
      check("fullrw.level", 32'(bus.fifo_level), 16);
      check("fullrw.ovr",   32'(bus.sts_overrun), 0);
      check("fullrw.head",  32'(bus.rd_data), 32'h41);
      bus.cfg_thresh = 5'd16;
      tick(); tick();
      check("thresh16.irq", 32'(bus.irq), 1);

      // Framing error, clear, and clear colliding with a new error
      bus.cfg_thresh = '0;
      bus.cfg_flush = 1'b1; tick(); bus.cfg_flush = 1'b0;
      tick();
      frame(8'h55, 1'b1);
      check("ferr.level", 32'(bus.fifo_level), 0);
      check("ferr.flag",  32'(bus.sts_frame_err), 1);
      tick();
      check("ferr.irq", 32'(bus.irq), 1);
      bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;
      check("clr.flag", 32'(bus.sts_frame_err), 0);
      tick();
      check("clr.irq", 32'(bus.irq), 0);
      bus.clr_err = 1'b1;
      frame(8'h77, 1'b1);
      bus.clr_err = 1'b0;
      check("clrset.flag", 32'(bus.sts_frame_err), 1);
      bus.clr_err = 1'b1; tick(); bus.clr_err = 1'b0;

      // Disable mid-frame: STOPPING still captures, then OFF
      bus.rx_busy = 1'b1;
      bus.cfg_en  = 1'b0;
      tick();
      check("stop.state", 32'(bus.ctrl_state), 3);
      check("stop.rx_en", 32'(bus.rx_en), 0);
      frame(8'h3C, 1'b0);
      check("stop.level", 32'(bus.fifo_level), 1);
      check("stop.data",  32'(bus.rd_data), 32'h3C);
      bus.rx_busy = 1'b0;
      tick();
      check("stop.off", 32'(bus.ctrl_state), 0);

      // Reset in the middle of FLUSH
      bus.cfg_en = 1'b1;
      tick(); tick();
      check("midflush.state", 32'(bus.ctrl_state), 1);
      PRESETn = 1'b0;
      tick();
      check("midrst.state",  32'(bus.ctrl_state), 0);
      check("midrst.rx_rst", 32'(bus.rx_rst), 0);
      check("midrst.level",  32'(bus.fifo_level), 0);
      check("midrst.empty",  32'(bus.fifo_empty), 1);
      check("midrst.data",   32'(bus.rd_data), 0);
      bus.cfg_en = 1'b0;
      PRESETn = 1'b1;
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
